// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, video DMA, CPU) in front of a single SDRAM port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE, with CPU anti-starvation and a WAIT timeout.
module mem_arbiter #(
    parameter int AW         = 25,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_din,
    output logic          ld_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ready,
    output logic [1:0]    owner,
    output logic          timeout_err,
    output logic          drop_err
);

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_CPU  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e          state_q;
    logic [1:0]      owner_q;
    logic            op_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_din_q;
    logic            mem_we_q;
    logic            mem_rd_q;
    logic [7:0]      rdata_q;
    logic            ld_ack_q;
    logic            vid_ack_q;
    logic            cpu_ack_q;
    logic            timeout_err_q;
    logic            drop_err_q;
    logic [WCW-1:0]  wait_cnt_q;
    logic [SCW-1:0]  starve_cnt_q;

    logic            ld_pend_q;
    logic            ld_we_q;
    logic [AW-1:0]   ld_addr_q;
    logic [7:0]      ld_din_q;
    logic            vid_pend_q;
    logic [AW-1:0]   vid_addr_q;
    logic            cpu_pend_q;
    logic            cpu_we_q;
    logic [AW-1:0]   cpu_addr_q;
    logic [7:0]      cpu_din_q;

    logic            ld_clr, vid_clr, cpu_clr;
    logic            ld_take, vid_take, cpu_take;
    logic            drop_d;
    logic            cpu_first;
    logic [1:0]      grant_d;

    // A request arriving in its own ack cycle is taken: the set beats the DONE clear.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ld_clr   = 1'b0;
        vid_clr  = 1'b0;
        cpu_clr  = 1'b0;
        if (state_q == DONE) begin
            ld_clr  = (owner_q == OWN_LD);
            vid_clr = (owner_q == OWN_VID);
            cpu_clr = (owner_q == OWN_CPU);
        end
        ld_take  = ld_req  && (!ld_pend_q  || ld_clr);
        vid_take = vid_req && (!vid_pend_q || vid_clr);
        cpu_take = cpu_req && (!cpu_pend_q || cpu_clr);
        drop_d   = (ld_req && !ld_take) || (vid_req && !vid_take) || (cpu_req && !cpu_take);
    end

    always_comb begin
        grant_d   = OWN_NONE;
        cpu_first = cpu_pend_q && (starve_cnt_q >= SCW'(STARVE_MAX));
        if (ld_pend_q)
            grant_d = OWN_LD;
        else if (vid_pend_q && !cpu_first)
            grant_d = OWN_VID;
        else if (cpu_pend_q)
            grant_d = OWN_CPU;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ld_pend_q  <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_addr_q  <= '0;
            ld_din_q   <= '0;
            vid_pend_q <= 1'b0;
            vid_addr_q <= '0;
            cpu_pend_q <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (ld_take) begin
                ld_pend_q <= 1'b1;
                ld_we_q   <= ld_we;
                ld_addr_q <= ld_addr;
                ld_din_q  <= ld_din;
            end else if (ld_clr) begin
                ld_pend_q <= 1'b0;
            end
            if (vid_take) begin
                vid_pend_q <= 1'b1;
                vid_addr_q <= vid_addr;
            end else if (vid_clr) begin
                vid_pend_q <= 1'b0;
            end
            if (cpu_take) begin
                cpu_pend_q <= 1'b1;
                cpu_we_q   <= cpu_we;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end else if (cpu_clr) begin
                cpu_pend_q <= 1'b0;
            end
            if (drop_d)
                drop_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= OWN_NONE;
            op_we_q       <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rdata_q       <= '0;
            ld_ack_q      <= 1'b0;
            vid_ack_q     <= 1'b0;
            cpu_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            starve_cnt_q  <= '0;
        end else begin
            if (!cpu_pend_q)
                starve_cnt_q <= '0;
            else if (state_q == IDLE && grant_d == OWN_CPU)
                starve_cnt_q <= '0;
            else if (state_q == IDLE && grant_d == OWN_VID && starve_cnt_q != SCW'(STARVE_MAX))
                starve_cnt_q <= starve_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (grant_d != OWN_NONE) begin
                        owner_q    <= grant_d;
                        wait_cnt_q <= '0;
                        state_q    <= ISSUE;
                        case (grant_d)
                            OWN_LD: begin
                                mem_addr_q <= ld_addr_q;
                                mem_din_q  <= ld_din_q;
                                op_we_q    <= ld_we_q;
                            end
                            OWN_VID: begin
                                mem_addr_q <= vid_addr_q;
                                mem_din_q  <= '0;
                                op_we_q    <= 1'b0;
                            end
                            default: begin
                                mem_addr_q <= cpu_addr_q;
                                mem_din_q  <= cpu_din_q;
                                op_we_q    <= cpu_we_q;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    mem_we_q <= op_we_q;
                    mem_rd_q <= !op_we_q;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    // The strobe cycle itself is not a wait cycle; mem_ready is honoured from the next one.
                    if (mem_we_q || mem_rd_q) begin
                        mem_we_q <= 1'b0;
                        mem_rd_q <= 1'b0;
                    end else if (mem_ready || wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                        if (!mem_ready)
                            timeout_err_q <= 1'b1;
                        if (!op_we_q)
                            rdata_q <= mem_ready ? mem_dout : 8'hFF;
                        ld_ack_q  <= (owner_q == OWN_LD);
                        vid_ack_q <= (owner_q == OWN_VID);
                        cpu_ack_q <= (owner_q == OWN_CPU);
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    ld_ack_q  <= 1'b0;
                    vid_ack_q <= 1'b0;
                    cpu_ack_q <= 1'b0;
                    owner_q   <= OWN_NONE;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ld_ack      = ld_ack_q;
    assign vid_ack     = vid_ack_q;
    assign cpu_ack     = cpu_ack_q;
    assign rdata       = rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_we      = mem_we_q;
    assign mem_rd      = mem_rd_q;
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a delayed-ready memory responder, strobe and ack scoreboards,
// a vector table of single transactions and hand-written multi-cycle sequences.
module tb_mem_arbiter;

    localparam int AW         = 25;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 63;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ld_req = 1'b0, ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_din = '0;
    logic          ld_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic          cpu_ack;
    logic [7:0]    rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we, mem_rd;
    logic [7:0]    mem_dout = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    owner;
    logic          timeout_err, drop_err;

    mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready),
        .owner(owner), .timeout_err(timeout_err), .drop_err(drop_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [1:0] who;
        logic [7:0] rdata;
    } ack_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    din;
    } stb_exp_t;

    typedef struct {
        int            who;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        int            delay;
    } vec_t;

    ack_exp_t   ack_q[$];
    stb_exp_t   stb_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         ready_delay = 0;
    int         strobe_cyc = -1;
    int         strobe_cnt = 0;
    int         ack_cyc = -1;
    int         restarve = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by reads: a fixed function of the address.
    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    // Queue one expected transaction in grant order.
    task automatic expect_txn(input int who, input logic we, input logic [AW-1:0] a,
                              input logic [7:0] d, input logic timed_out);
        ack_exp_t ae;
        stb_exp_t se;
        se.addr = a;
        se.we   = we;
        se.din  = d;
        stb_q.push_back(se);
        if (!we)
            last_rd = timed_out ? 8'hFF : mem_f(a);
        ae.who   = 2'(who);
        ae.rdata = last_rd;
        ack_q.push_back(ae);
    endtask

    task automatic drive(input int who, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
        case (who)
            1: begin ld_req = 1'b1; ld_we = we; ld_addr = a; ld_din = d; end
            2: begin vid_req = 1'b1; vid_addr = a; end
            default: begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; end
        endcase
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
        ld_req  = 1'b0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((ack_q.size() != 0 || owner != 2'd0) && n < budget) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        check({name, "_drained"}, 32'(ack_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 32'({mem_we, mem_rd, ld_ack, vid_ack, cpu_ack, timeout_err, drop_err, owner}), 32'd0);
        check({name, "_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_data"}, 32'({mem_din, rdata}), 32'd0);
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Memory responder: mem_ready for one cycle, ready_delay cycles after the first wait cycle.
    always begin
        int d;
        @(negedge clk_sys);
        if (reset_n && (mem_rd || mem_we) && ready_delay >= 0) begin
            d = ready_delay;
            @(posedge clk_sys);
            repeat (d) @(posedge clk_sys);
            #1;
            mem_ready = 1'b1;
            mem_dout  = mem_f(mem_addr);
            @(posedge clk_sys);
            #1;
            mem_ready = 1'b0;
            mem_dout  = 8'h00;
        end
    end

    // Re-pulse vid_req in its own ack cycle to keep video pending.
    always begin
        @(negedge clk_sys);
        if (reset_n && restarve > 0 && vid_ack) begin
            restarve--;
            vid_req = 1'b1;
            @(posedge clk_sys);
            #1;
            vid_req = 1'b0;
        end
    end

    // Strobe and ack scoreboards, sampled mid-cycle.
    always @(negedge clk_sys) begin
        ack_exp_t ae;
        stb_exp_t se;
        int       who;
        if (reset_n) begin
            if (mem_rd || mem_we) begin
                strobe_cnt++;
                strobe_cyc = cyc;
                check("strobe_exclusive", 32'(mem_rd & mem_we), 32'd0);
                if (stb_q.size() == 0) begin
                    check("strobe_unexpected", 32'd1, 32'd0);
                end else begin
                    se = stb_q.pop_front();
                    check("strobe_addr", 32'(mem_addr), 32'(se.addr));
                    check("strobe_we", 32'(mem_we), 32'(se.we));
                    if (se.we)
                        check("strobe_din", 32'(mem_din), 32'(se.din));
                end
            end
            if (ld_ack || vid_ack || cpu_ack) begin
                ack_cyc = cyc;
                check("ack_onehot", 32'(ld_ack) + 32'(vid_ack) + 32'(cpu_ack), 32'd1);
                who = ld_ack ? 1 : (vid_ack ? 2 : 3);
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    check("ack_who", 32'(who), 32'(ae.who));
                    check("ack_owner", 32'(owner), 32'(ae.who));
                    check("ack_rdata", 32'(rdata), 32'(ae.rdata));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   e, s0, n, s_ack;

        vecs[0] = '{1, 1'b1, 25'h0000010, 8'hC3, 0};
        vecs[1] = '{1, 1'b0, 25'h0000010, 8'h00, 1};
        vecs[2] = '{2, 1'b0, 25'h01ABCDE, 8'h00, 2};
        vecs[3] = '{3, 1'b1, 25'h0000155, 8'h77, 0};
        vecs[4] = '{3, 1'b0, 25'h1FFFFFF, 8'h00, 3};
        vecs[5] = '{2, 1'b0, 25'h0000000, 8'h00, 0};
        vecs[6] = '{3, 1'b0, 25'h00000AA, 8'h00, 5};

        // Reset state, with a request pulse that must be ignored.
        cpu_req = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        cpu_req = 1'b0;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        check("reset_no_grant", 32'(owner), 32'd0);

        // Single CPU read with minimum latency.
        ready_delay = 0;
        s0 = strobe_cnt;
        drive(3, 1'b0, 25'h0000123, 8'h00);
        expect_txn(3, 1'b0, 25'h0000123, 8'h00, 1'b0);
        step();
        e = cyc;
        wait_idle("lat", 50);
        check("lat_strobe_cycle", 32'(strobe_cyc), 32'(e + 2));
        check("lat_strobe_count", 32'(strobe_cnt - s0), 32'd1);
        check("lat_ack_cycle", 32'(ack_cyc), 32'(e + 4));
        check("lat_rdata", 32'(rdata), 32'h5A);

        // Vector table of isolated transactions.
        foreach (vecs[i]) begin
            ready_delay = vecs[i].delay;
            drive(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].din);
            expect_txn(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].din, 1'b0);
            step();
            e = cyc;
            wait_idle($sformatf("vec%0d", i), 60);
            check($sformatf("vec%0d_ack_cycle", i), 32'(ack_cyc), 32'(e + 4 + vecs[i].delay));
        end

        // Simultaneous requests: ld, then vid, then cpu.
        ready_delay = 1;
        s0 = strobe_cnt;
        drive(1, 1'b1, 25'h0000010, 8'hC3);
        drive(2, 1'b0, 25'h0002000, 8'h00);
        drive(3, 1'b0, 25'h0003000, 8'h00);
        expect_txn(1, 1'b1, 25'h0000010, 8'hC3, 1'b0);
        expect_txn(2, 1'b0, 25'h0002000, 8'h00, 1'b0);
        expect_txn(3, 1'b0, 25'h0003000, 8'h00, 1'b0);
        step();
        wait_idle("simul", 80);
        check("simul_strobes", 32'(strobe_cnt - s0), 32'd3);

        // A loader request mid-transaction waits for the CPU transaction to finish.
        ready_delay = 4;
        drive(3, 1'b0, 25'h0000321, 8'h00);
        expect_txn(3, 1'b0, 25'h0000321, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 25'h0000400, 8'h5E, 1'b0);
        step();
        @(posedge clk_sys);
        #1;
        @(posedge clk_sys);
        #1;
        drive(1, 1'b1, 25'h0000400, 8'h5E);
        step();
        wait_idle("nopreempt", 80);

        // Starvation: video kept pending, CPU waits for exactly STARVE_MAX video grants.
        ready_delay = 0;
        restarve = STARVE_MAX;
        drive(2, 1'b0, 25'h0000040, 8'h00);
        drive(3, 1'b0, 25'h0000080, 8'h00);
        for (int k = 0; k < STARVE_MAX; k++)
            expect_txn(2, 1'b0, 25'h0000040, 8'h00, 1'b0);
        expect_txn(3, 1'b0, 25'h0000080, 8'h00, 1'b0);
        expect_txn(2, 1'b0, 25'h0000040, 8'h00, 1'b0);
        step();
        wait_idle("starve", 200);
        check("starve_repulses_used", 32'(restarve), 32'd0);

        // Request in the ack cycle is captured and executed, without a drop.
        ready_delay = 0;
        drive(3, 1'b0, 25'h00000C0, 8'h00);
        expect_txn(3, 1'b0, 25'h00000C0, 8'h00, 1'b0);
        step();
        n = 0;
        while (!cpu_ack && n < 20) begin
            @(negedge clk_sys);
            n++;
        end
        check("overlap_ack_seen", 32'(cpu_ack), 32'd1);
        drive(3, 1'b0, 25'h00000D0, 8'h00);
        expect_txn(3, 1'b0, 25'h00000D0, 8'h00, 1'b0);
        step();
        wait_idle("overlap", 50);
        check("overlap_no_drop", 32'(drop_err), 32'd0);

        // Second request while pending is dropped; original address is used.
        ready_delay = 6;
        drive(3, 1'b0, 25'h00000E0, 8'h00);
        expect_txn(3, 1'b0, 25'h00000E0, 8'h00, 1'b0);
        step();
        @(posedge clk_sys);
        #1;
        drive(3, 1'b0, 25'h00000F0, 8'h00);
        step();
        wait_idle("drop", 60);
        check("drop_err_set", 32'(drop_err), 32'd1);

        // Timeout: memory never answers.
        ready_delay = -1;
        drive(3, 1'b0, 25'h0000111, 8'h00);
        expect_txn(3, 1'b0, 25'h0000111, 8'h00, 1'b1);
        step();
        e = cyc;
        wait_idle("timeout", 200);
        check("timeout_ack_cycle", 32'(ack_cyc), 32'(e + 3 + TIMEOUT));
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        ready_delay = 0;
        drive(2, 1'b0, 25'h0000222, 8'h00);
        expect_txn(2, 1'b0, 25'h0000222, 8'h00, 1'b0);
        step();
        wait_idle("post_timeout", 50);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Reset during WAIT abandons the transaction with no ack.
        ready_delay = -1;
        drive(2, 1'b0, 25'h0000333, 8'h00);
        stb_q.push_back('{25'h0000333, 1'b0, 8'h00});
        step();
        repeat (5) @(posedge clk_sys);
        #1;
        check("rst_mid_in_wait", 32'(owner), 32'd2);
        s_ack = ack_cyc;
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_mid_no_ack", 32'(ack_cyc), 32'(s_ack));
        check_all_zero("rst_mid_hold");
        ack_q.delete();
        last_rd = 8'h00;
        reset_n = 1'b1;
        ready_delay = 0;
        @(posedge clk_sys);
        #1;
        drive(2, 1'b0, 25'h0000444, 8'h00);
        expect_txn(2, 1'b0, 25'h0000444, 8'h00, 1'b0);
        step();
        e = cyc;
        wait_idle("after_reset", 50);
        check("after_reset_ack_cycle", 32'(ack_cyc), 32'(e + 4));

        check("end_strobe_queue", 32'(stb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
